alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one instance of the team's combinational ALU between two requesters: requester A is the execute-stage datapath and requester B is the address/branch helper. Each requester presents operands and a 4-bit ALU opcode with a valid/ready handshake. The block grants one request at a time using round-robin priority, registers the operands, and runs them through the ALU. It then holds a tagged result, with zero and error flags, until the consumer accepts it.

## Interface
- n, 64, operand and result width in bits
- input_clk  in  1  clock; all state updates on the rising edge
- input_reset  in  1  synchronous, active-high reset
- input_valid_a  in  1  requester A has a request
- input_data_1_a, input_data_2_a  in  n  requester A operands
- input_opcode_a  in  4  requester A ALU opcode
- output_ready_a  out  1  A's request is accepted this cycle if input_valid_a=1
- input_valid_b, input_data_1_b, input_data_2_b, input_opcode_b  in  1/n/n/4  same meaning for requester B
- output_ready_b  out  1  same meaning for requester B
- output_result_valid  out  1  a result is held
- output_result_id  out  1  0 = result belongs to A, 1 = result belongs to B
- output_result  out  n  registered ALU result
- output_result_zero  out  1  output_result == 0
- output_result_error  out  1  the opcode was unsupported
- input_result_ready  in  1  consumer accepts the held result

## Operation
- State machine: IDLE -> EXEC -> HOLD -> IDLE.
- IDLE:
  - output_ready_a = (ptr==A) | ~input_valid_b.
  - output_ready_b = (ptr==B) | ~input_valid_a.
  - The ready outputs never depend on the requester's own valid.
  - Handshake occurs when valid & ready. On a handshake, latch operands, opcode and id, flip ptr to the other requester, and go to EXEC.
  - With no valid requests, stay in IDLE and leave ptr unchanged.
- EXEC:
  - Apply the latched operands to the ALU.
  - Register the result and flags into the output registers, and go to HOLD.
  - Both ready outputs are 0.
- HOLD:
  - output_result_valid=1.
  - When input_result_ready=1, go to IDLE. Otherwise stay in HOLD with all outputs stable.
  - Both ready outputs are 0.
- Opcodes (n-bit, wrap-around, no carry or overflow outputs):
  - 0010 add
  - 0110 subtract (data_1 − data_2)
  - 0000 AND
  - 0001 OR
  - 0111 pass data_2
  - 1100 NOR
- Any other opcode:
  - Do not drive it into the ALU.
  - output_result=0, output_result_zero=1, output_result_error=1.
  - It still completes the full handshake and counts as a grant.
- output_result_zero is 1 bit and is computed from the registered result. output_result_error is 0 for supported opcodes.
- Result registers keep their value after consumption until the next EXEC. output_result_valid drops to 0 in IDLE.

## Timing
- Reset (takes effect at the next edge, whatever the current state):
  - state=IDLE, ptr=A.
  - output_result_valid=0, output_result_id=0, output_result=0, output_result_zero=0, output_result_error=0.
  - The in-flight request is discarded and no result is produced for it.
- Cycle-level latency:
  - Handshake in cycle 0.
  - EXEC in cycle 1.
  - output_result_valid=1 from cycle 2.
  - With input_result_ready=1 in cycle 2, IDLE in cycle 3 and the next handshake can occur in cycle 3.
  - Peak throughput is 1 request per 3 cycles.
- Simultaneous A and B valid in IDLE: ptr decides the grant. The loser's request must be held stable by its requester and is granted at the next IDLE.
- A requester that deasserts valid without a handshake is legal. No state changes.
- input_result_ready outside HOLD is ignored.
- Operand or opcode changes after the handshake do not affect the held result.

## Test plan
- Reset, then A only:
  - Stimulus: input_valid_a=1, data_1=5, data_2=3, opcode 0010.
  - Required: ready_a=1 in cycle 0. Result valid in cycle 2 with result=8, id=0, zero=0, error=0.
- Contention:
  - Stimulus: A and B valid every cycle. A: 7−7, opcode 0110. B: 0xF0 OR 0x0F, opcode 0001. input_result_ready=1.
  - Required: grants alternate A, B, A. A results are 0 with zero=1. B results are 0xFF with id=1. A new grant every 3 cycles.
- Backpressure:
  - Stimulus: input_result_ready=0 for 5 cycles in HOLD, with B valid.
  - Required: result, id and flags stable. ready_a=ready_b=0 throughout. B is granted in the cycle after ready=1 is seen.
- Wrap and NOR:
  - Stimulus: 0xFFFF_FFFF_FFFF_FFFF + 1 (opcode 0010), then NOR of 0 with 0 (opcode 1100).
  - Required: first result 0 with zero=1. Second result all-ones.
- Unsupported opcode:
  - Stimulus: opcode 1111 with operands 9 and 9.
  - Required: result=0, zero=1, error=1. ptr still flips.
- Mid-operation reset:
  - Stimulus: assert input_reset in EXEC, then A valid with 2+2.
  - Required: no result valid for the aborted request. The next result is 4 with id=0, and A wins first (ptr=A).

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between an execute-stage
// requester (A) and an address/branch helper (B); results are held until consumed.

module alu_arbiter_alu #(
    parameter int n = 64
) (
    input  logic [n-1:0] i_a,
    input  logic [n-1:0] i_b,
    input  logic [3:0]   i_opcode,
    output logic [n-1:0] o_result
);
    always_comb begin
        o_result = '0;
        case (i_opcode)
            4'b0010: o_result = i_a + i_b;
            4'b0110: o_result = i_a - i_b;
            4'b0000: o_result = i_a & i_b;
            4'b0001: o_result = i_a | i_b;
            4'b0111: o_result = i_b;
            4'b1100: o_result = ~(i_a | i_b);
            default: o_result = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int n = 64
) (
    input  logic         input_clk,
    input  logic         input_reset,
    input  logic         input_valid_a,
    input  logic [n-1:0] input_data_1_a,
    input  logic [n-1:0] input_data_2_a,
    input  logic [3:0]   input_opcode_a,
    output logic         output_ready_a,
    input  logic         input_valid_b,
    input  logic [n-1:0] input_data_1_b,
    input  logic [n-1:0] input_data_2_b,
    input  logic [3:0]   input_opcode_b,
    output logic         output_ready_b,
    output logic         output_result_valid,
    output logic         output_result_id,
    output logic [n-1:0] output_result,
    output logic         output_result_zero,
    output logic         output_result_error,
    input  logic         input_result_ready
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic         id;
        logic [3:0]   opcode;
        logic [n-1:0] d1;
        logic [n-1:0] d2;
    } req_t;

    state_t       r_state, w_state_next;
    logic         r_ptr, w_ptr_next;       // 0: A has priority, 1: B has priority
    req_t         r_req, w_req_next;
    logic         w_hs_a, w_hs_b;

    logic         w_op_ok;
    logic [n-1:0] w_alu_a, w_alu_b, w_alu_y;
    logic [3:0]   w_alu_op;

    logic [n-1:0] r_result;
    logic         r_id, r_zero, r_error;

    always_ff @(posedge input_clk) begin
        if (input_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_ptr_next     = r_ptr;
        w_req_next     = r_req;
        output_ready_a = 1'b0;
        output_ready_b = 1'b0;
        w_hs_a         = 1'b0;
        w_hs_b         = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Readies look only at the other side's valid, so at most one handshake fires.
                output_ready_a = ~r_ptr | ~input_valid_b;
                output_ready_b =  r_ptr | ~input_valid_a;
                w_hs_a = input_valid_a & output_ready_a;
                w_hs_b = input_valid_b & output_ready_b;
                if (w_hs_b) begin
                    w_req_next.id     = 1'b1;
                    w_req_next.opcode = input_opcode_b;
                    w_req_next.d1     = input_data_1_b;
                    w_req_next.d2     = input_data_2_b;
                    w_ptr_next        = 1'b0;
                    w_state_next      = S_EXEC;
                end else if (w_hs_a) begin
                    w_req_next.id     = 1'b0;
                    w_req_next.opcode = input_opcode_a;
                    w_req_next.d1     = input_data_1_a;
                    w_req_next.d2     = input_data_2_a;
                    w_ptr_next        = 1'b1;
                    w_state_next      = S_EXEC;
                end
            end
            S_EXEC: w_state_next = S_HOLD;
            S_HOLD: if (input_result_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge input_clk) begin
        if (input_reset) begin
            r_ptr <= 1'b0;
            r_req <= '0;
        end else begin
            r_ptr <= w_ptr_next;
            r_req <= w_req_next;
        end
    end

    always_comb begin
        case (r_req.opcode)
            4'b0010, 4'b0110, 4'b0000,
            4'b0001, 4'b0111, 4'b1100: w_op_ok = 1'b1;
            default:                   w_op_ok = 1'b0;
        endcase
    end

    // Unsupported opcodes present zeros as an AND, so the shared ALU stays quiet and yields 0.
    assign w_alu_a  = w_op_ok ? r_req.d1     : '0;
    assign w_alu_b  = w_op_ok ? r_req.d2     : '0;
    assign w_alu_op = w_op_ok ? r_req.opcode : 4'b0000;

    alu_arbiter_alu #(.n(n)) u_alu (
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .i_opcode (w_alu_op),
        .o_result (w_alu_y)
    );

    always_ff @(posedge input_clk) begin
        if (input_reset) begin
            r_result <= '0;
            r_id     <= 1'b0;
            r_zero   <= 1'b0;
            r_error  <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_result <= w_alu_y;
            r_id     <= r_req.id;
            r_zero   <= (w_alu_y == '0);
            r_error  <= ~w_op_ok;
        end
    end

    assign output_result_valid = (r_state == S_HOLD);
    assign output_result_id    = r_id;
    assign output_result       = r_result;
    assign output_result_zero  = r_zero;
    assign output_result_error = r_error;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, multi-cycle corner sequences,
// then randomized transactions against a behavioural model.

module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        va, vb, ra, rb, rr;
    logic [63:0] a1, a2, b1, b2;
    logic [3:0]  aop, bop;
    logic        res_v, res_id, res_z, res_e;
    logic [63:0] res;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.n(64)) dut (
        .input_clk           (clk),
        .input_reset         (rst),
        .input_valid_a       (va),
        .input_data_1_a      (a1),
        .input_data_2_a      (a2),
        .input_opcode_a      (aop),
        .output_ready_a      (ra),
        .input_valid_b       (vb),
        .input_data_1_b      (b1),
        .input_data_2_b      (b2),
        .input_opcode_b      (bop),
        .output_ready_b      (rb),
        .output_result_valid (res_v),
        .output_result_id    (res_id),
        .output_result       (res),
        .output_result_zero  (res_z),
        .output_result_error (res_e),
        .input_result_ready  (rr)
    );

    typedef struct {
        logic        va;
        logic [63:0] a1, a2;
        logic [3:0]  aop;
        logic        vb;
        logic [63:0] b1, b2;
        logic [3:0]  bop;
        logic        era, erb, eid;
        logic [63:0] eres;
        logic        ez, ee;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        va = 0; vb = 0; rr = 0;
        a1 = 0; a2 = 0; b1 = 0; b2 = 0; aop = 0; bop = 0;
    endtask

    // Reference ALU from the opcode table: {error, result}
    function automatic logic [64:0] ref_alu(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        case (op)
            4'b0010: return {1'b0, x + y};
            4'b0110: return {1'b0, x - y};
            4'b0000: return {1'b0, x & y};
            4'b0001: return {1'b0, x | y};
            4'b0111: return {1'b0, y};
            4'b1100: return {1'b0, ~(x | y)};
            default: return {1'b1, 64'd0};
        endcase
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 3))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [3:0] rnd_op();
        logic [3:0] ops[6];
        int idx;
        ops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};
        idx = $urandom_range(0, 7);
        if (idx < 6) return ops[idx];
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        logic        m_ptr, win;
        logic [64:0] r;
        logic [63:0] all1;
        int          n_hs, last_cyc, k;
        logic        last_id;

        all1 = '1;
        //            va a1          a2     aop      vb b1     b2     bop      ra rb id res                   z  e
        tbl[0] = '{1'b1, 64'd5,      64'd3, 4'b0010, 1'b0, 64'd0,    64'd0,    4'b0000, 1'b1, 1'b0, 1'b0, 64'd8,    1'b0, 1'b0};
        tbl[1] = '{1'b1, all1,       64'd1, 4'b0010, 1'b0, 64'd0,    64'd0,    4'b0000, 1'b1, 1'b1, 1'b0, 64'd0,    1'b1, 1'b0};
        tbl[2] = '{1'b0, 64'd0,      64'd0, 4'b0000, 1'b1, 64'd0,    64'd0,    4'b1100, 1'b0, 1'b1, 1'b1, all1,     1'b0, 1'b0};
        tbl[3] = '{1'b1, 64'd7,      64'd7, 4'b0110, 1'b1, 64'hF0,   64'h0F,   4'b0001, 1'b1, 1'b0, 1'b0, 64'd0,    1'b1, 1'b0};
        tbl[4] = '{1'b1, 64'd7,      64'd7, 4'b0110, 1'b1, 64'hF0,   64'h0F,   4'b0001, 1'b0, 1'b1, 1'b1, 64'hFF,   1'b0, 1'b0};
        tbl[5] = '{1'b1, 64'd9,      64'd9, 4'b1111, 1'b0, 64'd0,    64'd0,    4'b0000, 1'b1, 1'b0, 1'b0, 64'd0,    1'b1, 1'b1};
        tbl[6] = '{1'b1, 64'd9,      64'd9, 4'b1111, 1'b1, 64'hF0,   64'h0F,   4'b0000, 1'b0, 1'b1, 1'b1, 64'd0,    1'b1, 1'b0};
        tbl[7] = '{1'b1, 64'd1, 64'h1234,   4'b0111, 1'b0, 64'd0,    64'd0,    4'b0000, 1'b1, 1'b0, 1'b0, 64'h1234, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 64'd0,      64'd0, 4'b0000, 1'b1, 64'd3,    64'd5,    4'b0110, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 64'd20,     64'd6, 4'b0011, 1'b0, 64'd0,    64'd0,    4'b0000, 1'b1, 1'b0, 1'b0, 64'd0,    1'b1, 1'b1};

        rst = 1;
        quiet();
        step();
        step();
        chkb("reset result_valid", res_v, 1'b0);
        chkb("reset result_id", res_id, 1'b0);
        chk ("reset result", res, 64'd0);
        chkb("reset zero", res_z, 1'b0);
        chkb("reset error", res_e, 1'b0);
        rst = 0;
        #1;
        chkb("idle ready_a", ra, 1'b1);
        chkb("idle ready_b", rb, 1'b1);

        // Directed table: each entry is one full transaction starting from IDLE
        for (int i = 0; i < 10; i++) begin
            va = tbl[i].va; a1 = tbl[i].a1; a2 = tbl[i].a2; aop = tbl[i].aop;
            vb = tbl[i].vb; b1 = tbl[i].b1; b2 = tbl[i].b2; bop = tbl[i].bop;
            rr = 0;
            #1;
            chkb($sformatf("v%0d ready_a", i), ra, tbl[i].era);
            chkb($sformatf("v%0d ready_b", i), rb, tbl[i].erb);
            step();
            chkb($sformatf("v%0d exec ready_a", i), ra, 1'b0);
            chkb($sformatf("v%0d exec ready_b", i), rb, 1'b0);
            chkb($sformatf("v%0d exec valid", i), res_v, 1'b0);
            va = 0; vb = 0;
            a1 = rnd64(); a2 = rnd64(); b1 = rnd64(); b2 = rnd64(); aop = rnd_op(); bop = rnd_op();
            step();
            chkb($sformatf("v%0d valid", i), res_v, 1'b1);
            chkb($sformatf("v%0d id", i), res_id, tbl[i].eid);
            chk ($sformatf("v%0d result", i), res, tbl[i].eres);
            chkb($sformatf("v%0d zero", i), res_z, tbl[i].ez);
            chkb($sformatf("v%0d error", i), res_e, tbl[i].ee);
            rr = 1;
            step();
            rr = 0;
            chkb($sformatf("v%0d idle valid", i), res_v, 1'b0);
            chk ($sformatf("v%0d kept result", i), res, tbl[i].eres);
        end

        // Contention: both valid every cycle; ptr is at B after the table
        va = 1; a1 = 64'd7; a2 = 64'd7; aop = 4'b0110;
        vb = 1; b1 = 64'hF0; b2 = 64'h0F; bop = 4'b0001;
        rr = 1;
        n_hs = 0; last_cyc = 0; last_id = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (res_v) begin
                chk("contention result", res, res_id ? 64'hFF : 64'd0);
                chkb("contention zero", res_z, ~res_id);
            end
            if ((va & ra) | (vb & rb)) begin
                if (n_hs == 0) begin
                    chkb("contention first grant", vb & rb, 1'b1);
                end else begin
                    chk("contention spacing", 64'(c - last_cyc), 64'd3);
                    chkb("contention alternates", vb & rb, ~last_id);
                end
                last_id = vb & rb;
                last_cyc = c;
                n_hs++;
            end
            step();
        end
        chk("contention grant count", 64'(n_hs), 64'd4);
        quiet();
        step(); step(); step();

        // Backpressure: A granted alone (ptr is B), then B waits through a stalled HOLD
        va = 1; a1 = 64'd10; a2 = 64'd20; aop = 4'b0010;
        #1;
        chkb("bp ready_a", ra, 1'b1);
        step();
        va = 0;
        vb = 1; b1 = 64'd1; b2 = 64'd1; bop = 4'b0010;
        step();
        for (int c = 0; c < 5; c++) begin
            chkb("bp valid", res_v, 1'b1);
            chk ("bp result", res, 64'd30);
            chkb("bp id", res_id, 1'b0);
            chkb("bp zero", res_z, 1'b0);
            chkb("bp error", res_e, 1'b0);
            chkb("bp ready_a", ra, 1'b0);
            chkb("bp ready_b", rb, 1'b0);
            step();
        end
        rr = 1;
        step();
        rr = 0;
        chkb("bp idle valid", res_v, 1'b0);
        chkb("bp b granted", rb & vb, 1'b1);
        step();
        vb = 0;
        step();
        chk ("bp b result", res, 64'd2);
        chkb("bp b id", res_id, 1'b1);
        rr = 1;
        step();
        rr = 0;

        // Mid-operation reset: ptr moves to B on the grant, reset must restore A priority
        va = 1; a1 = 64'd6; a2 = 64'd6; aop = 4'b0010;
        step();
        va = 0;
        rst = 1;
        step();
        rst = 0;
        chkb("mrst valid", res_v, 1'b0);
        chk ("mrst result", res, 64'd0);
        chkb("mrst id", res_id, 1'b0);
        chkb("mrst zero", res_z, 1'b0);
        step();
        chkb("mrst no result", res_v, 1'b0);
        va = 1; a1 = 64'd2; a2 = 64'd2; aop = 4'b0010;
        vb = 1; b1 = 64'd1; b2 = 64'd1; bop = 4'b0010;
        #1;
        chkb("mrst ready_a", ra, 1'b1);
        chkb("mrst ready_b", rb, 1'b0);
        step();
        va = 0; vb = 0;
        step();
        chkb("mrst valid2", res_v, 1'b1);
        chk ("mrst result2", res, 64'd4);
        chkb("mrst id2", res_id, 1'b0);
        rr = 1;
        step();
        rr = 0;

        // Randomized transactions against the model; A was granted last, so B has priority
        m_ptr = 1'b1;
        for (int t = 0; t < 200; t++) begin
            va = 1'($urandom_range(0, 1)); vb = 1'($urandom_range(0, 1));
            a1 = rnd64(); a2 = rnd64(); aop = rnd_op();
            b1 = rnd64(); b2 = rnd64(); bop = rnd_op();
            rr = 1'($urandom_range(0, 1));
            #1;
            chkb("rnd ready_a", ra, (m_ptr == 1'b0) | ~vb);
            chkb("rnd ready_b", rb, (m_ptr == 1'b1) | ~va);
            if (!va && !vb) begin
                step();
                chkb("rnd idle stays", res_v, 1'b0);
                continue;
            end
            win = (va && vb) ? m_ptr : vb;
            r = win ? ref_alu(bop, b1, b2) : ref_alu(aop, a1, a2);
            m_ptr = ~win;
            step();
            va = 1'($urandom_range(0, 1)); vb = 1'($urandom_range(0, 1));
            a1 = rnd64(); b1 = rnd64(); aop = rnd_op(); bop = rnd_op();
            rr = 0;
            step();
            k = $urandom_range(0, 3);
            for (int s = 0; s <= k; s++) begin
                chkb("rnd valid", res_v, 1'b1);
                chkb("rnd id", res_id, win);
                chk ("rnd result", res, r[63:0]);
                chkb("rnd zero", res_z, r[63:0] == 64'd0);
                chkb("rnd error", res_e, r[64]);
                if (s < k) step();
            end
            rr = 1;
            step();
            rr = 0; va = 0; vb = 0;
            #1;
            chkb("rnd back to idle", res_v, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
